// File: rtl/bsm1e_pkg.sv
// bsm1e_pkg: shared types and constants for the fetch path.
//   addr_t        15-bit instruction address
//   byte_t        8-bit instruction byte
//   fetch_state_t fetch FSM state encoding
//   RESET_VECTOR  fetch pointer value after reset
package bsm1e_pkg;

  typedef logic [14:0] addr_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  localparam addr_t RESET_VECTOR = 15'h0000;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small prefetch FIFO of (address, byte) entries, head at slot 0.
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   push, push_addr/data  write one entry (ignored when full unless popping)
//   pop                   drop the head entry (ignored when empty)
//   flush                 empty the buffer; overrides push and pop
//   full, empty           occupancy flags
//   head_addr, head_data  head entry contents (stale when empty)
module fetch_buffer
  import bsm1e_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  push,
  input  addr_t push_addr,
  input  byte_t push_data,
  input  logic  pop,
  input  logic  flush,
  output logic  full,
  output logic  empty,
  output addr_t head_addr,
  output byte_t head_data
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);
  localparam int         LAST      = DEPTH - 1;

  addr_t      addr_q [DEPTH];
  byte_t      data_q [DEPTH];
  logic [1:0] count;
  logic       pop_ok;
  logic       push_ok;
  int         wr_idx;

  assign empty     = (count == 2'd0);
  assign full      = (count == DEPTH_CNT);
  assign head_addr = addr_q[0];
  assign head_data = data_q[0];

  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same edge, so a full buffer may still push.
  assign push_ok = push && (!full || pop_ok);

  // Entries shift toward the head on a pop, so the write lands one slot lower.
  always_comb begin
    wr_idx = pop_ok ? int'(count) - 1 : int'(count);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (i == wr_idx)) begin
          addr_q[i] <= push_addr;
          data_q[i] <= push_data;
        end else if (pop_ok && (i < LAST)) begin
          addr_q[i] <= addr_q[(i < LAST) ? i + 1 : i];
          data_q[i] <= data_q[(i < LAST) ? i + 1 : i];
        end
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential byte fetcher with branch flush and prefetch buffer.
// Ports:
//   clock, reset_n               rising-edge clock, async active-low reset
//   branch, branch_address       branch request and target
//   reset_branch                 one-cycle acknowledge of a sampled branch
//   mem_req, mem_address         memory read request / address (held until ack)
//   mem_ack, mem_data            read complete / returned byte
//   instr_valid, instr_data      head byte available / its value (0 when empty)
//   current_address              head byte address, or fetch pointer when empty
//   instr_ready                  decoder pops the head byte
// Build option: FETCH_UNIT_PREFETCH_EN defined selects a 2-entry buffer so a
// fetch can proceed while a byte waits; otherwise the buffer holds one byte.
//
// state   | meaning
// IDLE    | no read outstanding; issue when a buffer slot is (or becomes) free
// WAIT    | read outstanding; byte is pushed on mem_ack
// DISCARD | read outstanding after a branch; byte is dropped on mem_ack
module fetch_unit
  import bsm1e_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  branch,
  input  addr_t branch_address,
  output logic  reset_branch,
  output addr_t current_address,
  output logic  mem_req,
  output addr_t mem_address,
  input  logic  mem_ack,
  input  byte_t mem_data,
  output logic  instr_valid,
  output byte_t instr_data,
  input  logic  instr_ready
);

`ifdef FETCH_UNIT_PREFETCH_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  localparam logic [1:0] ST_IDLE    = FS_IDLE;
  localparam logic [1:0] ST_WAIT    = FS_WAIT;
  localparam logic [1:0] ST_DISCARD = FS_DISCARD;

  logic [1:0] state;
  logic [1:0] state_nxt;
  addr_t      fetch_ptr;
  logic       buf_full;
  logic       buf_empty;
  logic       push;
  logic       pop;
  addr_t      head_addr;
  byte_t      head_data;

  // A branch flushes the buffer in the same edge, so it also cancels any pop/push.
  assign pop  = instr_valid && instr_ready && !branch;
  assign push = (state == ST_WAIT) && mem_ack && !branch;

  assign mem_req         = (state != ST_IDLE);
  assign instr_valid     = !buf_empty;
  assign current_address = buf_empty ? fetch_ptr : head_addr;
  assign instr_data      = buf_empty ? '0 : head_data;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!branch && (!buf_full || pop)) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack)     state_nxt = ST_IDLE;
        else if (branch) state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      fetch_ptr    <= RESET_VECTOR;
      mem_address  <= '0;
      reset_branch <= 1'b0;
    end else begin
      state        <= state_nxt;
      reset_branch <= branch;
      if (branch)    fetch_ptr <= branch_address;
      else if (push) fetch_ptr <= fetch_ptr + 15'd1;
      // Address is captured only at issue, so it stays put through DISCARD.
      if ((state == ST_IDLE) && (state_nxt == ST_WAIT)) mem_address <= fetch_ptr;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (mem_address),
    .push_data (mem_data),
    .pop       (pop),
    .flush     (branch),
    .full      (buf_full),
    .empty     (buf_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clock  input  1  rising-edge clock; reset_n  input  1  async active-low reset.
REQ-002 branch  input  1  branch request from the control-flow unit, sampled each rising edge.
REQ-003 branch_address  input  15  branch target, valid while branch=1.
REQ-004 reset_branch  output  1  one-cycle acknowledge that clears the control-flow unit's branch flag.
REQ-005 current_address  output  15  address of the byte presented on instr_data.
REQ-006 mem_req  output  1  memory read request.
REQ-007 mem_address  output  15  read address.
REQ-008 mem_ack  input  1  read complete; mem_data valid this cycle.
REQ-009 mem_data  input  8  read data.
REQ-010 instr_valid  output  1  instr_data holds a fetched byte.
REQ-011 instr_data  output  8  byte at FIFO head.
REQ-012 instr_ready  input  1  decoder accepts head byte; pop when instr_valid&&instr_ready.

Function
REQ-013 The block SHALL keep a 15-bit fetch pointer and a prefetch buffer of (address, byte) entries; instr_valid = buffer non-empty; current_address/instr_data = head entry, or the fetch pointer and 0 when empty.
REQ-014 FSM states IDLE, WAIT, DISCARD: IDLE->WAIT when buffer has a free slot after any same-cycle pop (mem_req=1, mem_address=fetch pointer); WAIT->IDLE on mem_ack (push byte with its address, pointer+1); WAIT->DISCARD on branch without mem_ack; DISCARD->IDLE on mem_ack (byte dropped).
REQ-015 mem_req and mem_address SHALL stay stable from issue until the mem_ack cycle inclusive; at most one outstanding read; mem_req deasserted in the cycle after mem_ack.
REQ-016 Fetch pointer SHALL wrap 0x7FFF -> 0x0000 with no gap or stall.
REQ-017 On branch=1 the block SHALL in that edge flush the buffer, load the fetch pointer with branch_address, and assert reset_branch for exactly the following cycle.
REQ-018 branch and instr_ready in the same cycle: flush wins, pop ignored.
REQ-019 branch and mem_ack in the same cycle: returned byte discarded, state -> IDLE.
REQ-020 branch while reset_branch=1 SHALL be accepted as a new branch (latest target wins, reset_branch stays high one more cycle).
REQ-021 Push and pop in the same cycle on a full buffer SHALL be legal; count unchanged.
REQ-022 Latency: first instr_valid after branch no earlier than 2 cycles after the edge sampling branch with mem_ack tied high.

Reset
REQ-023 While reset_n=0: state IDLE, fetch pointer 0x0000, buffer empty, reset_branch=0, mem_req=0, mem_address=0, instr_valid=0, instr_data=0, current_address=0.
REQ-024 Reset asserted mid-request SHALL abandon it; the memory side tolerates a dropped request.

Configuration
REQ-025 Macro FETCH_UNIT_PREFETCH_EN: defined -> buffer depth 2, fetch continues while one byte waits; undefined -> depth 1, next fetch issues only after the head is popped; all other requirements identical.

Structure
REQ-026 Shared package bsm1e_pkg SHALL hold addr_t (15 bits), byte_t (8 bits), fetch_state_t enum, RESET_VECTOR=15'h0000.
REQ-027 Buffer SHALL be sub-module fetch_buffer (parameter DEPTH 1 or 2; push, pop, flush, full, empty); FSM and pointer in fetch_unit.

Verification
REQ-028 Reset release, mem_ack=1 always, instr_ready=1 -> mem_address 0,1,2,... ; instr_data/current_address track memory image in order.
REQ-029 Pointer at 0x7FFE, sequential run -> addresses 0x7FFE,0x7FFF,0x0000 with no bubble.
REQ-030 branch=1, branch_address=0x1234 while WAIT and mem_ack delayed 3 cycles -> reset_branch high exactly 1 cycle, delayed byte never seen, next current_address=0x1234.
REQ-031 instr_ready=0 for 10 cycles (PREFETCH_EN) -> exactly 2 reads issued, mem_req low until pop; without macro -> exactly 1.
REQ-032 branch and mem_ack and instr_ready same cycle, target 0x0040 -> buffer empty, no byte pushed, next fetch at 0x0040.
REQ-033 reset_n pulsed low during WAIT -> all outputs 0 asynchronously; fetch restarts at 0x0000.
